quantum_op_sequencer: RTL

Command front-end that sits directly upstream of the quantum operation controller. It buffers host-issued quantum operations in a command FIFO and issues them one at a time over the controller's op_code/op_param/op_start interface. It then waits for op_done/op_error, bounded by a timeout, and posts a tagged completion record into a completion FIFO for the host. Illegal opcodes are rejected locally and never reach the controller.

---
 rtl/quantum_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/quantum_op_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/quantum_pkg.sv
// Shared opcode, completion-status and FSM-state definitions for the
// quantum operation command front-end.
package quantum_pkg;

  localparam logic [3:0] OP_IDLE          = 4'd0;
  localparam logic [3:0] OP_PREPARE       = 4'd1;
  localparam logic [3:0] OP_MEASURE       = 4'd2;
  localparam logic [3:0] OP_FACTOR        = 4'd3;
  localparam logic [3:0] OP_SEARCH        = 4'd4;
  localparam logic [3:0] OP_OPTIMIZE      = 4'd5;
  localparam logic [3:0] OP_ERROR_CORRECT = 4'd6;

  localparam logic [1:0] CPL_OK      = 2'b00;
  localparam logic [1:0] CPL_ERROR   = 2'b01;
  localparam logic [1:0] CPL_TIMEOUT = 2'b10;
  localparam logic [1:0] CPL_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_CPL,
    ST_GAP
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op >= OP_PREPARE) && (op <= OP_ERROR_CORRECT);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; full/empty derive from the
// registered occupancy count. Storage is not reset, so dout is raw.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // A push at full is refused even when a pop happens in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/quantum_op_sequencer.sv
// Buffers host quantum operations, issues them one at a time to the
// controller, supervises done/error/timeout and posts tagged completions.
module quantum_op_sequencer
  import quantum_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int CPL_DEPTH      = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [63:0]      cmd_param,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       op_code,
  output logic [127:0]     op_param,
  output logic             op_start,
  input  logic             op_done,
  input  logic             op_error,
  input  logic [127:0]     op_result,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [TAG_W-1:0] cpl_tag,
  output logic [1:0]       cpl_status,
  output logic [31:0]      cpl_data,
  output logic             busy
);

  localparam int CMD_W = 4 + 64 + TAG_W;
  localparam int CPL_W = TAG_W + 2 + 32;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  state_t                    state, state_nxt;
  logic [CMD_W-1:0]          cmd_head;
  logic                      cmd_full, cmd_empty;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  logic [CPL_W-1:0]          cpl_head, cpl_shown;
  logic                      cpl_full, cpl_empty;
  logic [$clog2(CPL_DEPTH):0] cpl_count;

  logic [3:0]       head_op;
  logic [63:0]      head_param;
  logic [TAG_W-1:0] head_tag;

  logic             cmd_pop, cpl_push, load_op, st_load;
  logic [1:0]       st_val;
  logic             cnt_clr, cnt_inc, gap_clr, gap_inc;
  logic [TO_W-1:0]  cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [63:0]      op_param_r;
  logic [TAG_W-1:0] tag_r;
  logic [1:0]       status_r;
  logic [31:0]      data_r;
  logic             unused_result;

  assign head_op    = cmd_head[CMD_W-1 -: 4];
  assign head_param = cmd_head[TAG_W +: 64];
  assign head_tag   = cmd_head[TAG_W-1:0];

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (cmd_valid),
    .din   ({cmd_opcode, cmd_param, cmd_tag}),
    .rd_en (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.WIDTH(CPL_W), .DEPTH(CPL_DEPTH)) u_cpl_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (cpl_push),
    .din   ({tag_r, status_r, data_r}),
    .rd_en (cpl_ready),
    .dout  (cpl_head),
    .full  (cpl_full),
    .empty (cpl_empty),
    .count (cpl_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    cpl_push  = 1'b0;
    load_op   = 1'b0;
    st_load   = 1'b0;
    st_val    = status_r;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    gap_clr   = 1'b0;
    gap_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          if (op_is_legal(head_op)) begin
            load_op   = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            st_load   = 1'b1;
            st_val    = CPL_ILLEGAL;
            state_nxt = ST_CPL;
          end
        end
      end
      ST_ISSUE: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_inc = 1'b1;
        if (op_error) begin
          st_load   = 1'b1;
          st_val    = CPL_ERROR;
          cnt_clr   = 1'b1;
          state_nxt = op_done ? ST_CPL : ST_DRAIN;
        end else if (op_done) begin
          st_load   = 1'b1;
          st_val    = CPL_OK;
          state_nxt = ST_CPL;
        end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          st_load   = 1'b1;
          st_val    = CPL_TIMEOUT;
          state_nxt = ST_CPL;
        end
      end
      ST_DRAIN: begin
        // Swallow the controller's trailing done pulse, but never wait long.
        cnt_inc = 1'b1;
        if (op_done || (cnt == TO_W'(1))) state_nxt = ST_CPL;
      end
      ST_CPL: begin
        if (!cpl_full) begin
          cpl_push  = 1'b1;
          gap_clr   = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_inc = 1'b1;
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Start is registered off ISSUE so it lands in the first WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_start   <= 1'b0;
      op_code    <= '0;
      op_param_r <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
    end else begin
      op_start <= (state == ST_ISSUE);
      if (load_op) begin
        op_code    <= head_op;
        op_param_r <= head_param;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + TO_W'(1);
      if (gap_clr)      gap_cnt <= '0;
      else if (gap_inc) gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_pop) tag_r <= head_tag;
    if (st_load) begin
      status_r <= st_val;
      data_r   <= (st_val == CPL_OK) ? op_result[31:0] : 32'd0;
    end
  end

  assign unused_result = ^op_result[127:32];

  assign op_param   = {64'd0, op_param_r};
  assign cmd_ready  = !cmd_full;
  assign busy       = (state != ST_IDLE) || (cmd_count != '0);
  assign cpl_valid  = (cpl_count != '0);
  assign cpl_shown  = cpl_empty ? '0 : cpl_head;
  assign cpl_tag    = cpl_shown[CPL_W-1 -: TAG_W];
  assign cpl_status = cpl_shown[33:32];
  assign cpl_data   = cpl_shown[31:0];

endmodule
